fir_filter_mc: RTL and testbench

Multi-channel, time-multiplexed FIR filter: successor to the fully parallel single-channel FIR, generalised to C interleaved channels, each with an independent (N+1)-tap delay line. It shares one multiplier-accumulator and one coefficient set across channels. Samples enter through a valid/ready stream and results leave through a valid/ready stream. The block sits between a channel-tagged sample source (e.g. ADC/TDM deserialiser) and downstream DSP.

---
 rtl/fir_filter_mc_if.sv | 26 ++
 rtl/fir_filter_mc.sv | 116 +++++++++++
 tb/tb_fir_filter_mc.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_filter_mc_if.sv
// Stream bundle for fir_filter_mc: channel-tagged samples in, results out.
// The master side is the surrounding system; the slave side is the filter.
interface fir_filter_mc_if #(
  parameter int CW  = 1,
  parameter int W_X = 8,
  parameter int W_Y = 19
);
  logic                  s_valid;
  logic                  s_ready;
  logic [CW-1:0]         s_ch;
  logic signed [W_X-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [CW-1:0]         m_ch;
  logic signed [W_Y-1:0] m_data;

  modport master (
    output s_valid, s_ch, s_data, m_ready,
    input  s_ready, m_valid, m_ch, m_data
  );

  modport slave (
    input  s_valid, s_ch, s_data, m_ready,
    output s_ready, m_valid, m_ch, m_data
  );
endinterface

// File: rtl/fir_filter_mc.sv
// Time-multiplexed C-channel FIR sharing one MAC and one coefficient set.
// Define FIR_COEF_LOAD_EN for a runtime coefficient write port.
module fir_filter_mc #(
  parameter int N   = 5,
  parameter int C   = 2,
  parameter int W_X = 8,
  parameter int W_K = 8,
  parameter logic signed [W_K-1:0] K [N+1] =
    '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6},
  localparam int CW  = (C > 1) ? $clog2(C) : 1,
  localparam int TW  = (N > 0) ? $clog2(N + 1) : 1,
  localparam int W_Y = W_X + W_K + $clog2(N + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef FIR_COEF_LOAD_EN
  input  logic                  k_we,
  input  logic [TW-1:0]         k_addr,
  input  logic signed [W_K-1:0] k_data,
`endif
  fir_filter_mc_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                state;
  logic signed [W_X-1:0] z [C][N+1];
  logic signed [W_K-1:0] k [N+1];
  logic signed [W_Y-1:0] acc;
  logic [TW-1:0]         tap;
  logic [CW-1:0]         ch;
  logic                  mv;
  logic [CW-1:0]         mc;
  logic signed [W_Y-1:0] md;

  logic signed [W_X+W_K-1:0] prod;
  logic signed [W_Y-1:0]     sum;
  logic                      take;
  logic                      hit;
  logic                      last;

  assign prod = z[ch][tap] * k[tap];
  assign sum  = acc + W_Y'(prod);
  assign take = bus.s_valid && bus.s_ready;
  assign hit  = int'(bus.s_ch) < C;
  assign last = int'(tap) == N;

  assign bus.s_ready = (state == IDLE) && !rst;
  assign bus.m_valid = mv;
  assign bus.m_ch    = mc;
  assign bus.m_data  = md;

`ifdef FIR_COEF_LOAD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n <= N; n++) k[n] <= K[n];
    end else if (k_we && state == IDLE && int'(k_addr) <= N) begin
      k[k_addr] <= k_data;
    end
  end
`else
  assign k = K;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      tap   <= '0;
      ch    <= '0;
      mv    <= 1'b0;
      mc    <= '0;
      md    <= '0;
      for (int c = 0; c < C; c++)
        for (int n = 0; n <= N; n++)
          z[c][n] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // out-of-range channels are consumed without touching history
          if (take && hit) begin
            for (int c = 0; c < C; c++) begin
              if (c == int'(bus.s_ch)) begin
                z[c][0] <= bus.s_data;
                for (int n = 1; n <= N; n++)
                  z[c][n] <= z[c][n-1];
              end
            end
            acc   <= '0;
            tap   <= '0;
            ch    <= bus.s_ch;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= sum;
          tap <= tap + 1'b1;
          if (last) begin
            mv    <= 1'b1;
            md    <= sum;
            mc    <= ch;
            state <= OUT;
          end
        end
        OUT: begin
          if (bus.m_ready) begin
            mv    <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter_mc.sv
// Scoreboard bench for fir_filter_mc: reference FIR model feeds a queue,
// results are popped and compared at each output handshake.
module tb_fir_filter_mc;

  localparam int N   = 5;
  localparam int C   = 3;
  localparam int W_X = 8;
  localparam int W_K = 8;
  localparam int CW  = (C > 1) ? $clog2(C) : 1;
  localparam int W_Y = W_X + W_K + $clog2(N + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_filter_mc_if #(.CW(CW), .W_X(W_X), .W_Y(W_Y)) bus();

`ifdef FIR_COEF_LOAD_EN
  logic              k_we   = 1'b0;
  logic [2:0]        k_addr = '0;
  logic signed [7:0] k_data = '0;
`endif

  fir_filter_mc #(.N(N), .C(C), .W_X(W_X), .W_K(W_K)) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef FIR_COEF_LOAD_EN
    .k_we   (k_we),
    .k_addr (k_addr),
    .k_data (k_data),
`endif
    .bus    (bus)
  );

  typedef struct {
    int     ch;
    longint data;
    int     cyc;
  } exp_t;

  exp_t   q[$];
  int     n_vec = 0;
  int     n_bad = 0;
  int     cyc   = 0;
  bit     seen  = 1'b0;
  longint hist [C][N+1];
  longint coef [N+1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int c = 0; c < C; c++)
      for (int n = 0; n <= N; n++)
        hist[c][n] = 0;
    for (int n = 0; n <= N; n++) coef[n] = n + 1;
    q.delete();
    seen = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.m_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", bus.m_valid, 0);
      end else begin
        if (!seen) begin
          chk("latency", cyc - q[0].cyc, N + 1);
          seen = 1'b1;
        end
        if (bus.m_ready) begin
          chk("m_ch", bus.m_ch, q[0].ch);
          chk("m_data", bus.m_data, q[0].data);
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input int c, input int d);
    int     t = 0;
    longint s = 0;
    @(negedge clk);
    while (!bus.s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.s_ready) begin
      chk("s_ready_timeout", bus.s_ready, 1);
      return;
    end
    bus.s_valid = 1'b1;
    bus.s_ch    = CW'(c);
    bus.s_data  = W_X'(d);
    @(posedge clk);
    #1;
    if (c < C) begin
      for (int n = N; n > 0; n--) hist[c][n] = hist[c][n-1];
      hist[c][0] = d;
      for (int n = 0; n <= N; n++) s += coef[n] * hist[c][n];
      q.push_back('{ch: c, data: s, cyc: cyc});
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int t;
    bus.s_valid = 1'b0;
    bus.s_ch    = '0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    reset_model();

    repeat (2) @(negedge clk);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_m_ch", bus.m_ch, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", bus.s_ready, 1);

    // impulse on ch0: 1,2,3,4,5,6,0
    send(0, 1);
    repeat (6) send(0, 0);
    drain();

    // channel isolation: 1 (ch0), 10 (ch1), 2 (ch0)
    send(0, 1);
    send(1, 10);
    send(0, 0);
    drain();

    // out-of-range channel is swallowed
    send(3, 50);
    chk("drop_s_ready", bus.s_ready, 1);
    repeat (10) @(negedge clk);
    send(0, 0);
    drain();

    repeat (12) send(int'($urandom_range(0, C - 1)),
                     int'($urandom_range(0, 255)) - 128);
    drain();

    // back-pressure in OUT
    bus.m_ready = 1'b0;
    send(1, 7);
    t = 0;
    while (!bus.m_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_wait_valid", bus.m_valid, 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_m_valid", bus.m_valid, 1);
      chk("bp_m_data", bus.m_data, q[0].data);
      chk("bp_m_ch", bus.m_ch, q[0].ch);
      chk("bp_s_ready", bus.s_ready, 0);
    end
    @(posedge clk);
    #1 bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_ready", bus.s_ready, 1);
    chk("bp_valid_low", bus.m_valid, 0);
    drain();

`ifdef FIR_COEF_LOAD_EN
    for (int n = 0; n <= N; n++) begin
      @(negedge clk);
      k_we   = 1'b1;
      k_addr = 3'(n);
      k_data = 8'sh80;
      coef[n] = -128;
    end
    @(negedge clk);
    k_addr = 3'd7;
    k_data = 8'sd99;
    @(negedge clk);
    k_we = 1'b0;
    repeat (6) send(0, -128);
    send(0, -128);
    k_we   = 1'b1;
    k_addr = 3'd0;
    k_data = 8'sd1;
    @(posedge clk);
    #1 k_we = 1'b0;
    drain();
`endif

    // reset during MAC discards the in-flight result
    send(0, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    reset_model();
    repeat (N + 3) begin
      @(negedge clk);
      chk("rst_mac_m_valid", bus.m_valid, 0);
      chk("rst_mac_s_ready", bus.s_ready, 0);
    end
    rst = 1'b0;
    send(0, 1);
    send(0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
